// File: rtl/nrf_cmd_sequencer.sv
// Command/payload sequencer for an nRF24L01 over a byte-wide SPI engine.
// Frames one command byte plus up to MAX_LEN payload bytes under a single CSN assertion.
module nrf_cmd_sequencer #(
    parameter int MAX_LEN     = 32,
    parameter int CSN_SETUP   = 2,
    parameter int CSN_GAP     = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       clk_10,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic [5:0] cmd_len,
    output logic       wr_req,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic [7:0] status_out,
    output logic [7:0] byte_out,
    output logic       byte_start,
    input  logic [7:0] byte_in,
    input  logic       byte_done,
    output logic       csn,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, SETUP, LOAD, WAIT, HOLD} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  cmd_reg, cmd_next;
    logic [6:0]  len_reg, len_next;
    logic [6:0]  idx_reg, idx_next;
    logic [15:0] cnt_reg, cnt_next;
    logic        csn_reg, csn_next;
    logic        byte_start_reg, byte_start_next;
    logic        rd_valid_reg, rd_valid_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;
    logic        cmd_ready_reg, cmd_ready_next;
    logic        busy_reg, busy_next;
    logic [7:0]  byte_out_reg, byte_out_next;
    logic [7:0]  rd_data_reg, rd_data_next;
    logic [7:0]  status_reg, status_next;
    logic        wr_req_c;

    always_ff @(posedge clk_10) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cmd_reg        <= 8'h00;
            len_reg        <= 7'd0;
            idx_reg        <= 7'd0;
            cnt_reg        <= 16'd0;
            csn_reg        <= 1'b1;
            byte_start_reg <= 1'b0;
            rd_valid_reg   <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            cmd_ready_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            byte_out_reg   <= 8'h00;
            rd_data_reg    <= 8'h00;
            status_reg     <= 8'h00;
        end else begin
            state_reg      <= state_next;
            cmd_reg        <= cmd_next;
            len_reg        <= len_next;
            idx_reg        <= idx_next;
            cnt_reg        <= cnt_next;
            csn_reg        <= csn_next;
            byte_start_reg <= byte_start_next;
            rd_valid_reg   <= rd_valid_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
            cmd_ready_reg  <= cmd_ready_next;
            busy_reg       <= busy_next;
            byte_out_reg   <= byte_out_next;
            rd_data_reg    <= rd_data_next;
            status_reg     <= status_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cmd_next        = cmd_reg;
        len_next        = len_reg;
        idx_next        = idx_reg;
        cnt_next        = cnt_reg;
        csn_next        = csn_reg;
        byte_start_next = 1'b0;
        rd_valid_next   = 1'b0;
        done_next       = 1'b0;
        err_next        = 1'b0;
        byte_out_next   = byte_out_reg;
        rd_data_next    = rd_data_reg;
        status_next     = status_reg;
        wr_req_c        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cmd_valid && cmd_ready_reg) begin
                    state_next = SETUP;
                    cmd_next   = cmd_byte;
                    len_next   = ({1'b0, cmd_len} > 7'(MAX_LEN)) ? 7'(MAX_LEN) : {1'b0, cmd_len};
                    idx_next   = 7'd0;
                    cnt_next   = 16'd0;
                    csn_next   = 1'b0;
                end
            end
            SETUP: begin
                if (cnt_reg == 16'(CSN_SETUP - 1)) begin
                    state_next = LOAD;
                    cnt_next   = 16'd0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            LOAD: begin
                // Index 0 is the opcode; every later byte is pulled from the payload source.
                if (idx_reg == 7'd0) begin
                    byte_out_next = cmd_reg;
                end else begin
                    wr_req_c      = 1'b1;
                    byte_out_next = wr_data;
                end
                byte_start_next = 1'b1;
                cnt_next        = 16'd0;
                state_next      = WAIT;
            end
            WAIT: begin
                if (byte_done) begin
                    if (idx_reg == 7'd0) begin
                        status_next = byte_in;
                    end else begin
                        rd_data_next  = byte_in;
                        rd_valid_next = 1'b1;
                    end
                    idx_next = idx_reg + 7'd1;
                    if (idx_reg == len_reg) begin
                        csn_next   = 1'b1;
                        done_next  = 1'b1;
                        cnt_next   = 16'd0;
                        state_next = HOLD;
                    end else begin
                        state_next = LOAD;
                    end
                end else if (cnt_reg == 16'(TIMEOUT_CYC - 1)) begin
                    csn_next   = 1'b1;
                    err_next   = 1'b1;
                    cnt_next   = 16'd0;
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            HOLD: begin
                if (cnt_reg == 16'(CSN_GAP - 1)) begin
                    state_next = IDLE;
                    cnt_next   = 16'd0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        cmd_ready_next = (state_next == IDLE);
        busy_next      = (state_next != IDLE);
    end

    assign wr_req     = wr_req_c && rst;
    assign cmd_ready  = cmd_ready_reg;
    assign busy       = busy_reg;
    assign csn        = csn_reg;
    assign byte_start = byte_start_reg;
    assign rd_valid   = rd_valid_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign byte_out   = byte_out_reg;
    assign rd_data    = rd_data_reg;
    assign status_out = status_reg;

endmodule

// File: tb/tb_nrf_cmd_sequencer.sv
// Bench for nrf_cmd_sequencer: a byte-engine responder with random latency plus
// per-transaction expectations derived from command/length/data tables.
module tb_nrf_cmd_sequencer;

    localparam int MAXL      = 32;
    localparam int SETUP_LAT = 3;
    localparam int GAP       = 4;
    localparam int TMO       = 255;

    logic       clk_10 = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_byte = 8'h00;
    logic [5:0] cmd_len = 6'd0;
    logic       wr_req;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [7:0] status_out;
    logic [7:0] byte_out;
    logic       byte_start;
    logic [7:0] byte_in = 8'h00;
    logic       byte_done = 1'b0;
    logic       csn;
    logic       busy;
    logic       done;
    logic       err;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] tx_pay [64];
    logic [7:0] rx_in  [64];
    logic [7:0] model_status = 8'h00;

    always #50 clk_10 = ~clk_10;

    nrf_cmd_sequencer dut (
        .clk_10    (clk_10),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_byte  (cmd_byte),
        .cmd_len   (cmd_len),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .status_out(status_out),
        .byte_out  (byte_out),
        .byte_start(byte_start),
        .byte_in   (byte_in),
        .byte_done (byte_done),
        .csn       (csn),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) begin
            tx_pay[i] = 8'($urandom);
            rx_in[i]  = 8'($urandom);
        end
    endtask

    // Entered and left on a falling edge with cmd_ready expected high.
    task automatic run_txn(input logic [7:0] cb, input int cl, input bit withhold,
                           input bit stray, input int stop_at, input int dmax);
        logic [7:0] obs_out [$];
        logic [7:0] obs_rd [$];
        logic [7:0] e;
        int n_start = 0, n_wr = 0, n_done = 0, n_err = 0;
        int wr_i = 0, rx_i = 0, pend = -1;
        int t_start = -1, t_end = -1, b2b = 0, csn_break = 0, gap = 0, extra = 0;
        int mism_out = 0, mism_rd = 0, len_exp, g = 0;
        bit p_start = 0, p_wr = 0, p_rd = 0, p_done = 0, p_err = 0, fin = 0;

        len_exp = (cl > MAXL) ? MAXL : cl;
        if (stray) begin
            @(negedge clk_10);
            byte_done = 1'b1;
            byte_in   = 8'h5A;
            @(negedge clk_10);
            byte_done = 1'b0;
            chk("stray_idle_ready", 32'(cmd_ready), 32'd1);
            chk("stray_idle_csn", 32'(csn), 32'd1);
        end
        cmd_valid = 1'b1;
        cmd_byte  = cb;
        cmd_len   = 6'(cl);
        @(negedge clk_10);
        for (int t = 0; t < 3000 && !fin; t++) begin
            cmd_valid = 1'b0;
            byte_done = 1'b0;
            if (t == 0) begin
                chk("csn_low_on_accept", 32'(csn), 32'd0);
                cmd_byte = 8'($urandom);
                cmd_len  = 6'($urandom);
                if (stray) begin
                    cmd_valid = 1'b1;
                    byte_done = 1'b1;
                    byte_in   = 8'hA5;
                end
            end
            if (csn && !done && !err) csn_break++;
            if (byte_start) begin
                n_start++;
                obs_out.push_back(byte_out);
                if (n_start == 1) t_start = t;
                if (!withhold) pend = $urandom_range(dmax, 0);
                if (n_start == stop_at) begin
                    byte_done = 1'b0;
                    return;
                end
            end
            if (pend == 0) begin
                byte_done = 1'b1;
                byte_in   = rx_in[rx_i % 64];
                rx_i++;
                pend = -1;
            end else if (pend > 0) begin
                pend--;
            end
            if (wr_req) begin
                n_wr++;
                wr_data = tx_pay[wr_i % 64];
                wr_i++;
            end else begin
                wr_data = 8'($urandom);
            end
            if (rd_valid) obs_rd.push_back(rd_data);
            if (done) n_done++;
            if (err) n_err++;
            if (byte_start && p_start) b2b++;
            if (wr_req && p_wr) b2b++;
            if (rd_valid && p_rd) b2b++;
            if (done && p_done) b2b++;
            if (err && p_err) b2b++;
            p_start = byte_start;
            p_wr    = wr_req;
            p_rd    = rd_valid;
            p_done  = done;
            p_err   = err;
            if (done || err) begin
                fin   = 1'b1;
                t_end = t;
            end else begin
                @(negedge clk_10);
            end
        end
        chk("txn_finished", 32'(fin), 32'd1);
        byte_done = 1'b0;
        while (!cmd_ready && g < 100) begin
            if (csn) gap++;
            if (g > 0 && (done || err || byte_start || rd_valid || wr_req)) extra++;
            g++;
            @(negedge clk_10);
        end

        if (withhold) begin
            chk("to_starts", n_start, 32'd1);
            chk("to_err", n_err, 32'd1);
            chk("to_done", n_done, 32'd0);
            chk("to_rd_count", obs_rd.size(), 32'd0);
            chk("to_latency", t_end - t_start, TMO);
            chk("to_status_kept", 32'(status_out), 32'(model_status));
        end else begin
            for (int i = 0; i < obs_out.size() && i <= len_exp; i++) begin
                e = (i == 0) ? cb : tx_pay[(i + 63) % 64];
                if (obs_out[i] !== e) mism_out++;
            end
            for (int i = 0; i < obs_rd.size() && i < len_exp; i++) begin
                if (obs_rd[i] !== rx_in[i + 1]) mism_rd++;
            end
            chk("starts", n_start, 1 + len_exp);
            chk("wr_req_count", n_wr, len_exp);
            chk("byte_out_mismatches", mism_out, 32'd0);
            chk("rd_count", obs_rd.size(), len_exp);
            chk("rd_data_mismatches", mism_rd, 32'd0);
            chk("status", 32'(status_out), 32'(rx_in[0]));
            chk("done_count", n_done, 32'd1);
            chk("err_count", n_err, 32'd0);
            model_status = rx_in[0];
        end
        chk("setup_latency", t_start, SETUP_LAT);
        chk("csn_gap", gap, GAP);
        chk("csn_continuous", csn_break, 32'd0);
        chk("no_double_pulse", b2b, 32'd0);
        chk("quiet_hold", extra, 32'd0);
        $display("txn cmd=0x%02h len=%0d starts=%0d wr=%0d rd=%0d done=%0d err=%0d gap=%0d",
                 cb, cl, n_start, n_wr, obs_rd.size(), n_done, n_err, gap);
    endtask

    task automatic chk_reset_values(input string pfx);
        chk({pfx, "_csn"}, 32'(csn), 32'd1);
        chk({pfx, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_byte_start"}, 32'(byte_start), 32'd0);
        chk({pfx, "_wr_req"}, 32'(wr_req), 32'd0);
        chk({pfx, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({pfx, "_done"}, 32'(done), 32'd0);
        chk({pfx, "_err"}, 32'(err), 32'd0);
        chk({pfx, "_byte_out"}, 32'(byte_out), 32'd0);
        chk({pfx, "_rd_data"}, 32'(rd_data), 32'd0);
        chk({pfx, "_status"}, 32'(status_out), 32'd0);
    endtask

    initial begin
        fill_random();
        repeat (3) @(negedge clk_10);
        chk_reset_values("reset");
        rst = 1'b1;
        @(negedge clk_10);
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);
        chk("idle_not_busy", 32'(busy), 32'd0);

        // Command only
        rx_in[0] = 8'h0E;
        run_txn(8'hFF, 0, 1'b0, 1'b0, 0, 2);
        chk("cmd_only_status", 32'(status_out), 32'h0E);

        // Write payload
        fill_random();
        tx_pay[0] = 8'h11;
        tx_pay[1] = 8'h22;
        tx_pay[2] = 8'h33;
        run_txn(8'hA0, 3, 1'b0, 1'b0, 0, 3);

        // Read payload
        fill_random();
        rx_in[0] = 8'h0E;
        rx_in[1] = 8'hAB;
        rx_in[2] = 8'hCD;
        run_txn(8'h61, 2, 1'b0, 1'b0, 0, 1);
        chk("read_status", 32'(status_out), 32'h0E);
        chk("read_last_rd_data", 32'(rd_data), 32'hCD);

        // Timeout, then a normal follow-up
        fill_random();
        run_txn(8'($urandom), $urandom_range(5, 0), 1'b1, 1'b0, 0, 0);
        fill_random();
        run_txn(8'h61, 4, 1'b0, 1'b0, 0, 3);

        // Length clamp with stray byte_done / cmd_valid
        fill_random();
        run_txn(8'hA0, 40, 1'b0, 1'b1, 0, 2);

        for (int k = 0; k < 6; k++) begin
            fill_random();
            run_txn(8'($urandom), $urandom_range(40, 0), 1'b0, k[0], 0, $urandom_range(3, 0));
        end

        // Reset during the second WAIT
        fill_random();
        run_txn(8'hA0, 4, 1'b0, 1'b0, 2, 1);
        rst = 1'b0;
        @(negedge clk_10);
        chk_reset_values("midreset");
        rst = 1'b1;
        @(negedge clk_10);
        chk("ready_after_midreset", 32'(cmd_ready), 32'd1);
        model_status = 8'h00;
        fill_random();
        run_txn(8'h07, 1, 1'b0, 1'b0, 0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nrf_cmd_sequencer.md
NRF_CMD_SEQUENCER -- requirements
Module: nrf_cmd_sequencer

Interface
REQ-001 Parameter MAX_LEN, default 32: max payload bytes per transaction, excluding the command byte.
REQ-002 Parameter CSN_SETUP, default 2: clk_10 cycles CSN is held low before the first byte_start.
REQ-003 Parameter CSN_GAP, default 4: minimum clk_10 cycles CSN is held high between transactions.
REQ-004 Parameter TIMEOUT_CYC, default 255: WAIT cycles without byte_done before a transaction aborts.
REQ-005 clk_10  in  1  10 MHz system clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 cmd_valid  in  1  command request from top module.
REQ-008 cmd_ready  out  1  high only in IDLE; a transfer occurs when cmd_valid && cmd_ready.
REQ-009 cmd_byte  in  8  nRF24L01 command opcode; sampled on accept.
REQ-010 cmd_len  in  6  payload byte count (0..MAX_LEN); sampled on accept.
REQ-011 wr_req  out  1  one-cycle request for next TX payload byte.
REQ-012 wr_data  in  8  payload byte; must be valid in the same cycle wr_req is high.
REQ-013 rd_data  out  8  received payload byte; valid when rd_valid is high.
REQ-014 rd_valid  out  1  one-cycle strobe per received payload byte.
REQ-015 status_out  out  8  nRF STATUS byte, i.e. the byte clocked in during the command byte.
REQ-016 byte_out  out  8  byte to the downstream SPI byte engine.
REQ-017 byte_start  out  1  one-cycle start pulse to the byte engine.
REQ-018 byte_in  in  8  byte received by the byte engine; valid with byte_done.
REQ-019 byte_done  in  1  one-cycle completion pulse from the byte engine.
REQ-020 csn  out  1  nRF chip select, active-low, registered.
REQ-021 busy  out  1  high in every state except IDLE.
REQ-022 done  out  1  one-cycle pulse on normal completion.
REQ-023 err  out  1  one-cycle pulse on timeout abort.

Function
REQ-024 States: IDLE, SETUP, LOAD, WAIT, HOLD; no other states reachable.
- IDLE->SETUP on accept.
- SETUP->LOAD after CSN_SETUP cycles.
- LOAD->WAIT after one cycle.
- WAIT->LOAD on byte_done when more bytes remain.
- WAIT->HOLD on the last byte_done or on timeout.
- HOLD->IDLE after CSN_GAP cycles.
REQ-025 On accept, latch cmd_byte and min(cmd_len, MAX_LEN), clear byte index idx, and drive csn low at the same edge.
REQ-026 Transaction length is 1 + latched length bytes; cmd_len=0 sends only the command byte.
REQ-027 LOAD behaviour:
- idx=0: byte_out <= cmd_byte latch.
- idx>0: wr_req=1 combinationally for exactly that cycle and byte_out <= wr_data.
- In both cases byte_start <= 1, so the pulse is seen in the first WAIT cycle.
REQ-028 First byte_start is asserted exactly CSN_SETUP+1 cycles after csn falls.
REQ-029 On byte_done in WAIT:
- idx=0: status_out <= byte_in.
- idx>0: rd_data <= byte_in and rd_valid <= 1 for one cycle.
- idx increments in both cases.
REQ-030 On the byte_done that completes the final byte, csn <= 1 and done <= 1 at the same edge.
REQ-031 The WAIT counter resets on entry to WAIT. If it reaches TIMEOUT_CYC without byte_done: csn <= 1, err <= 1, done stays 0, no rd_valid, go to HOLD.
REQ-032 byte_done outside WAIT is ignored; it causes no capture, no strobe and no state change.
REQ-033 cmd_valid outside IDLE is ignored; it is not queued.
REQ-034 csn stays low continuously from accept until completion or abort, including between bytes.
REQ-035 byte_start, wr_req, rd_valid, done and err are never high for two consecutive cycles.

Reset
REQ-036 While rst=0 at a clock edge, the block forces the following:
- State: IDLE.
- csn=1.
- Outputs cleared: byte_start, wr_req, rd_valid, done, err, busy, cmd_ready all 0.
- Registers cleared: byte_out, rd_data, status_out all 0x00.
- Counters and idx: 0.
REQ-037 Reset asserted mid-transaction aborts it:
- csn goes high at that edge.
- No done or err pulse is generated.
REQ-038 cmd_ready goes to 1 on the first edge with rst=1.

Verification
REQ-039 Command-only transaction:
- Stimulus: cmd_byte=0xFF, cmd_len=0; engine returns byte_in=0x0E.
- Response: one byte_start with byte_out=0xFF; status_out=0x0E; done pulse; no rd_valid; csn low for the whole byte; csn high for 4 cycles before cmd_ready=1.
REQ-040 Write transaction:
- Stimulus: cmd_byte=0xA0, cmd_len=3; wr_data supplies 0x11, 0x22, 0x33.
- Response: byte_out sequence 0xA0, 0x11, 0x22, 0x33; three wr_req pulses; one done.
REQ-041 Read transaction:
- Stimulus: cmd_byte=0x61, cmd_len=2; byte_in sequence 0x0E, 0xAB, 0xCD.
- Response: status_out=0x0E; rd_valid twice with rd_data 0xAB then 0xCD.
REQ-042 Timeout:
- Stimulus: byte_done withheld 255 cycles after the first byte_start.
- Response: err pulse; csn=1; no done.
- Follow-up: a later command completes normally.
REQ-043 Length clamp and spurious inputs:
- Stimulus: cmd_len=40, plus stray byte_done pulses in IDLE and SETUP.
- Response: exactly 33 byte_start pulses; stray pulses cause no state change.
REQ-044 Reset mid-payload:
- Stimulus: rst=0 during the second WAIT.
- Response: csn=1 and all outputs at reset values at the next edge; cmd_ready=1 on the first edge after rst=1.
